i2s_frame_sequencer: RTL and testbench

I2S_FRAME_SEQUENCER -- requirements
Module: i2s_frame_sequencer

---
 rtl/i2s_pkg.sv | 25 ++
 rtl/i2s_frame_counter.sv | 38 +++
 rtl/i2s_frame_sequencer.sv | 128 ++++++++++++
 tb/tb_i2s_frame_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: sizes and state encoding shared by the I2S frame sequencer and
// the I2S receiver.
//   CH_BITS    - bits per channel sample
//   FRAME_BITS - bit clocks per stereo frame (left + right)
//   seq_state_t - IDLE / RUN / DRAIN sequencer states
package i2s_pkg;

    localparam int CH_BITS    = 16;
    localparam int FRAME_BITS = 32;
    localparam int CNT_BITS   = $clog2(FRAME_BITS);

    // Last bit position of a frame; also the parked counter value in IDLE.
    localparam logic [CNT_BITS-1:0] CNT_LAST  = CNT_BITS'(FRAME_BITS - 1);
    // First bit position belonging to the right channel.
    localparam logic [CNT_BITS-1:0] CNT_RIGHT = CNT_BITS'(CH_BITS);
    // word_select goes high one clock before the right-channel MSB.
    localparam logic [CNT_BITS-1:0] CNT_WS_HI = CNT_BITS'(CH_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/i2s_frame_counter.sv
// i2s_frame_counter: bit position within the stereo frame plus the
// word-select derivation.
//   serial_clk - bit clock, rising edge
//   reset      - asynchronous, active-low
//   run        - count this edge; when low the counter parks at the last bit
//   wrap_stop  - hold at the last bit instead of wrapping to 0
//   cnt        - current bit position, 0..FRAME_BITS-1
//   ws         - word select (0 = left, 1 = right), one-bit I2S delay
module i2s_frame_counter
    import i2s_pkg::*;
(
    input  logic                serial_clk,
    input  logic                reset,
    input  logic                run,
    input  logic                wrap_stop,
    output logic [CNT_BITS-1:0] cnt,
    output logic                ws
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            cnt <= CNT_LAST;
        end else if (!run) begin
            cnt <= CNT_LAST;
        end else if (wrap_stop && (cnt == CNT_LAST)) begin
            cnt <= CNT_LAST;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // The counter parks at CNT_LAST whenever idle, so ws is low in IDLE
    // without needing the busy state here.
    assign ws = (cnt >= CNT_WS_HI) && (cnt != CNT_LAST);

endmodule

// File: rtl/i2s_frame_sequencer.sv
// i2s_frame_sequencer: drives word_select to an I2S codec, deserialises the
// returned stereo frame and hands completed frames downstream through a
// valid/ready hold register with a sticky overrun flag.
//   serial_clk    - bit clock, rising edge
//   reset         - asynchronous, active-low
//   enable        - run request (level)
//   sound_data    - serial data from the codec, MSB first
//   out_ready     - downstream accepts the held frame
//   overrun_clear - clears the sticky overrun flag
//   word_select   - channel select to the codec (0 = left, 1 = right)
//   sample_left   - last delivered left sample
//   sample_right  - last delivered right sample
//   sample_valid  - a frame is held for downstream
//   overrun       - sticky: a completed frame was dropped
//   frame_count   - frames delivered, wraps 255 -> 0
//   busy          - high in RUN and DRAIN
module i2s_frame_sequencer
    import i2s_pkg::*;
(
    input  logic               serial_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               sound_data,
    input  logic               out_ready,
    input  logic               overrun_clear,
    output logic               word_select,
    output logic [CH_BITS-1:0] sample_left,
    output logic [CH_BITS-1:0] sample_right,
    output logic               sample_valid,
    output logic               overrun,
    output logic [7:0]         frame_count,
    output logic               busy
);

    seq_state_t          state;
    seq_state_t          next_state;
    logic [CNT_BITS-1:0] cnt;
    logic [CH_BITS-1:0]  left_shift;
    logic [CH_BITS-1:0]  right_shift;
    logic                frame_done;
    logic                load;
    logic                drop;
    logic                run;
    logic                wrap_stop;

    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable)  next_state = RUN;
            RUN:     if (!enable) next_state = DRAIN;
            // A drain always finishes the current frame; enable only matters
            // on the final bit, where it chains straight into the next frame.
            DRAIN:   if (cnt == CNT_LAST) next_state = enable ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign run        = busy || enable;
    assign wrap_stop  = (state == DRAIN) && !enable;
    assign frame_done = busy && (cnt == CNT_LAST);
    assign load       = frame_done && (!sample_valid || out_ready);
    assign drop       = frame_done && sample_valid && !out_ready;

    i2s_frame_counter u_counter (
        .serial_clk (serial_clk),
        .reset      (reset),
        .run        (run),
        .wrap_stop  (wrap_stop),
        .cnt        (cnt),
        .ws         (word_select)
    );

    // NOTE: the shift registers are plain flops with a reset value of zero,
    // so a partial frame never survives a reset.
    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            left_shift  <= '0;
            right_shift <= '0;
        end else if (busy) begin
            if (cnt < CNT_RIGHT) begin
                left_shift <= {left_shift[CH_BITS-2:0], sound_data};
            end else begin
                right_shift <= {right_shift[CH_BITS-2:0], sound_data};
            end
        end
    end

    // The right LSB arrives on the completion edge itself, so it is merged
    // directly into the output load rather than taken from right_shift.
    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            frame_count  <= '0;
        end else if (load) begin
            sample_left  <= left_shift;
            sample_right <= {right_shift[CH_BITS-2:0], sound_data};
            sample_valid <= 1'b1;
            frame_count  <= frame_count + 1'b1;
        end else if (sample_valid && out_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // A fresh overrun takes priority over a clear on the same edge.
    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clear) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// tb_i2s_frame_sequencer: directed scenarios for i2s_frame_sequencer with
// hand-computed expected frames, word-select timing and handshake results.
module tb_i2s_frame_sequencer;

    logic        serial_clk;
    logic        reset;
    logic        enable;
    logic        sound_data;
    logic        out_ready;
    logic        overrun_clear;
    logic        word_select;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        overrun;
    logic [7:0]  frame_count;
    logic        busy;

    int checks;
    int errors;

    i2s_frame_sequencer dut (
        .serial_clk    (serial_clk),
        .reset         (reset),
        .enable        (enable),
        .sound_data    (sound_data),
        .out_ready     (out_ready),
        .overrun_clear (overrun_clear),
        .word_select   (word_select),
        .sample_left   (sample_left),
        .sample_right  (sample_right),
        .sample_valid  (sample_valid),
        .overrun       (overrun),
        .frame_count   (frame_count),
        .busy          (busy)
    );

    initial serial_clk = 1'b0;
    always #5 serial_clk = ~serial_clk;

    task automatic tick();
        @(posedge serial_clk);
        #1;
    endtask

    // Starting from IDLE: the enable edge moves to RUN with cnt = 0.
    task automatic start_run();
        enable = 1'b1;
        tick();
    endtask

    // Drives one frame; expects the next edge to be cnt = 0.
    // en_mask[i] / rdy_mask[i] are enable / out_ready on the cnt = i edge.
    task automatic drive_frame(input logic [15:0] l, input logic [15:0] r,
                               input logic [31:0] en_mask,
                               input logic [31:0] rdy_mask,
                               input bit check_ws);
        for (int i = 0; i < 32; i++) begin
            sound_data = (i < 16) ? l[15-i] : r[31-i];
            enable     = en_mask[i];
            out_ready  = rdy_mask[i];
            if (check_ws) begin
                logic exp_ws;
                exp_ws = (i >= 15) && (i <= 30);
                checks++;
                if (word_select !== exp_ws) begin
                    errors++;
                    $display("FAIL ws_cnt%0d got %b want %b", i, word_select, exp_ws);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        enable        = 1'b0;
        sound_data    = 1'b0;
        out_ready     = 1'b0;
        overrun_clear = 1'b0;
        repeat (3) tick();
        checks++;
        if ({word_select, sample_left, sample_right, sample_valid, overrun,
             frame_count, busy} !== 44'd0) begin
            errors++;
            $display("FAIL reset_state got ws=%b l=%h r=%h v=%b ov=%b fc=%0d busy=%b",
                     word_select, sample_left, sample_right, sample_valid,
                     overrun, frame_count, busy);
        end
        #3 reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({busy, sample_valid} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b v=%b want 0 0", busy, sample_valid);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        start_run();
        checks++;
        if ({busy, word_select} !== 2'b10) begin
            errors++;
            $display("FAIL basic_start got busy=%b ws=%b want 1 0", busy, word_select);
        end
        drive_frame(16'hA5C3, 16'h1234, 32'h0, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if ({sample_valid, sample_left, sample_right, frame_count} !== {1'b1, 16'hA5C3, 16'h1234, 8'd1}) begin
            errors++;
            $display("FAIL basic_frame got v=%b l=%h r=%h fc=%0d want 1 a5c3 1234 1",
                     sample_valid, sample_left, sample_right, frame_count);
        end
        checks++;
        if ({busy, word_select} !== 2'b00) begin
            errors++;
            $display("FAIL basic_idle got busy=%b ws=%b want 0 0", busy, word_select);
        end
        tick();
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept got v=%b want 0", sample_valid);
        end
    endtask

    task automatic test_ws();
        out_ready = 1'b1;
        repeat (3) begin
            checks++;
            if (word_select !== 1'b0) begin
                errors++;
                $display("FAIL ws_idle got %b want 0", word_select);
            end
            tick();
        end
        start_run();
        drive_frame(16'h0001, 16'h8000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive_frame(16'hFFFF, 16'h0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive_frame(16'h5A5A, 16'hC3C3, 32'h0, 32'hFFFF_FFFF, 1'b1);
        checks++;
        if ({sample_valid, sample_left, sample_right, frame_count, busy, word_select}
            !== {1'b1, 16'h5A5A, 16'hC3C3, 8'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ws_three_frames got v=%b l=%h r=%h fc=%0d busy=%b ws=%b want 1 5a5a c3c3 4 0 0",
                     sample_valid, sample_left, sample_right, frame_count, busy, word_select);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start_run();
        drive_frame(16'h1111, 16'h2222, 32'hFFFF_FFFF, 32'h0, 1'b0);
        checks++;
        if ({sample_valid, overrun, sample_left, sample_right, frame_count}
            !== {1'b1, 1'b0, 16'h1111, 16'h2222, 8'd5}) begin
            errors++;
            $display("FAIL bp_first got v=%b ov=%b l=%h r=%h fc=%0d want 1 0 1111 2222 5",
                     sample_valid, overrun, sample_left, sample_right, frame_count);
        end
        drive_frame(16'h3333, 16'h4444, 32'h0, 32'h0, 1'b0);
        checks++;
        if ({sample_valid, overrun, sample_left, sample_right, frame_count}
            !== {1'b1, 1'b1, 16'h1111, 16'h2222, 8'd5}) begin
            errors++;
            $display("FAIL bp_dropped got v=%b ov=%b l=%h r=%h fc=%0d want 1 1 1111 2222 5",
                     sample_valid, overrun, sample_left, sample_right, frame_count);
        end
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        checks++;
        if ({overrun, sample_valid} !== 2'b01) begin
            errors++;
            $display("FAIL bp_clear got ov=%b v=%b want 0 1", overrun, sample_valid);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept got v=%b want 0", sample_valid);
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        start_run();
        drive_frame(16'hBEEF, 16'hCAFE, 32'hFFFF_FFFF, 32'h0, 1'b0);
        drive_frame(16'h0F0F, 16'hF00D, 32'h0, 32'h8000_0000, 1'b0);
        checks++;
        if ({sample_valid, overrun, sample_left, sample_right, frame_count}
            !== {1'b1, 1'b0, 16'h0F0F, 16'hF00D, 8'd7}) begin
            errors++;
            $display("FAIL simul_load got v=%b ov=%b l=%h r=%h fc=%0d want 1 0 0f0f f00d 7",
                     sample_valid, overrun, sample_left, sample_right, frame_count);
        end
        tick();
    endtask

    task automatic test_stop_restart();
        out_ready = 1'b1;
        start_run();
        // enable drops on the cnt = 5 edge; the drain still completes the frame
        drive_frame(16'h8001, 16'h7FFE, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if ({sample_valid, sample_left, sample_right, frame_count, busy, word_select}
            !== {1'b1, 16'h8001, 16'h7FFE, 8'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_drain got v=%b l=%h r=%h fc=%0d busy=%b ws=%b want 1 8001 7ffe 8 0 0",
                     sample_valid, sample_left, sample_right, frame_count, busy, word_select);
        end
        tick();
        start_run();
        // enable back on the cnt = 31 edge of the drain: no gap to next frame
        drive_frame(16'h1357, 16'h2468, 32'h8000_001F, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if ({sample_valid, sample_left, sample_right, busy}
            !== {1'b1, 16'h1357, 16'h2468, 1'b1}) begin
            errors++;
            $display("FAIL restart_frame got v=%b l=%h r=%h busy=%b want 1 1357 2468 1",
                     sample_valid, sample_left, sample_right, busy);
        end
        drive_frame(16'hABCD, 16'h9876, 32'h0, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if ({sample_valid, sample_left, sample_right, frame_count, busy}
            !== {1'b1, 16'hABCD, 16'h9876, 8'd10, 1'b0}) begin
            errors++;
            $display("FAIL restart_next got v=%b l=%h r=%h fc=%0d busy=%b want 1 abcd 9876 10 0",
                     sample_valid, sample_left, sample_right, frame_count, busy);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int bad_cycles;
        out_ready = 1'b0;
        start_run();
        drive_frame(16'h4242, 16'h2424, 32'hFFFF_FFFF, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            sound_data = i[0];
            tick();
        end
        checks++;
        if ({sample_valid, frame_count, busy} !== {1'b1, 8'd11, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre got v=%b fc=%0d busy=%b want 1 11 1",
                     sample_valid, frame_count, busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({word_select, sample_left, sample_right, sample_valid, overrun,
             frame_count, busy} !== 44'd0) begin
            errors++;
            $display("FAIL mid_reset got ws=%b l=%h r=%h v=%b ov=%b fc=%0d busy=%b",
                     word_select, sample_left, sample_right, sample_valid,
                     overrun, frame_count, busy);
        end
        enable = 1'b0;
        #2 reset = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            sound_data = ~sound_data;
            tick();
            if (sample_valid !== 1'b0 || busy !== 1'b0) bad_cycles++;
        end
        checks++;
        if (bad_cycles != 0) begin
            errors++;
            $display("FAIL mid_no_output got %0d active cycles want 0", bad_cycles);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_ws();
        test_backpressure();
        test_simultaneous();
        test_stop_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
